fnd_scan_ctrl: RTL and testbench

//  Parametrised time-multiplexed N-digit 7-segment scan controller; successor to the fixed 6-digit display driver.

---
 rtl/fnd_pkg.sv | 27 ++
 rtl/scan_slot_timer.sv | 41 ++++
 rtl/fnd_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display path: scan state encoding,
// pin polarity helpers and the {a..g} digit glyphs also used by fnd_dec.
package fnd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } scan_state_e;

    localparam int GLYPH_W = 7;

    localparam logic [GLYPH_W-1:0] GLYPH [10] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
    };

    // Inactive pin level: an active-low pin is off when driven high.
    function automatic logic seg_off(input int act_low);
        return (act_low != 0);
    endfunction

    function automatic logic enb_off(input int act_low);
        return (act_low != 0);
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-slot tick counter: blank phase first, then on phase, with strobes
// marking the last blank cycle and the last cycle of the slot.
module scan_slot_timer #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int TICK_W    = $clog2(SCAN_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic on_phase_o,
    output logic blank_end_o,
    output logic slot_end_o
);

    localparam logic [TICK_W-1:0] TICK_LAST       = TICK_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_BLANK_LAST = TICK_W'(BLANK_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_ON_FIRST   = TICK_W'(BLANK_CYC);

    logic [TICK_W-1:0] tick_q, tick_d;

    always_comb begin
        tick_d = tick_q + TICK_W'(1);
        if (!run_i || tick_q == TICK_LAST) begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign on_phase_o  = (tick_q >= TICK_ON_FIRST);
    assign blank_end_o = (tick_q == TICK_BLANK_LAST);
    assign slot_end_o  = (tick_q == TICK_LAST);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// N-digit 7-segment scan controller with per-frame input snapshot,
// inter-digit blanking, per-digit blink and configurable pin polarity.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | scan disabled, counters at 0, pins off
//   S_BLANK | leading part of a digit slot, all digits off
//   S_ON    | selected digit driven from the shadow copy
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int N_DIG        = 6,
    parameter int SEG_W        = 7,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 128,
    parameter int ENB_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW  = 0,
    localparam int DIG_W       = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic [N_DIG*SEG_W-1:0] i_digit_seg,
    input  logic [N_DIG-1:0]       i_dp,
    input  logic [N_DIG-1:0]       i_blink_mask,
    output logic [SEG_W-1:0]       o_seg,
    output logic                   o_seg_dp,
    output logic [N_DIG-1:0]       o_seg_enb,
    output logic [DIG_W-1:0]       o_dig_idx,
    output logic                   o_frame_start
);

    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIG - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic SEG_OFF_LVL = seg_off(SEG_ACT_LOW);
    localparam logic ENB_OFF_LVL = enb_off(ENB_ACT_LOW);

    scan_state_e state_q, state_d;
    logic on_phase, blank_end, slot_end;
    logic [DIG_W-1:0] dig_idx_q, dig_idx_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic blink_ph_q, blink_ph_d;
    logic fs_q;
    logic slot_adv, frame_start, frame_wrap;
    logic [N_DIG*SEG_W-1:0] seg_sh_q;
    logic [N_DIG-1:0] dp_sh_q, mask_sh_q;

    logic lit;
    logic [SEG_W-1:0] seg_pin_q, seg_pin_d;
    logic dp_pin_q, dp_pin_d;
    logic [N_DIG-1:0] enb_pin_q, enb_pin_d;
    logic [DIG_W-1:0] idx_pin_q;
    logic fs_pin_q;

    scan_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       ((state_q != S_IDLE) && i_en),
        .on_phase_o  (on_phase),
        .blank_end_o (blank_end),
        .slot_end_o  (slot_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_BLANK;
                S_BLANK: if (blank_end) state_d = S_ON;
                S_ON:    if (slot_end)  state_d = S_BLANK;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        slot_adv    = i_en && (state_q == S_ON) && slot_end;
        frame_wrap  = slot_adv && (dig_idx_q == DIG_LAST);
        frame_start = (i_en && (state_q == S_IDLE)) || frame_wrap;

        dig_idx_d = dig_idx_q;
        if (!i_en || state_q == S_IDLE || frame_wrap) begin
            dig_idx_d = '0;
        end else if (slot_adv) begin
            dig_idx_d = dig_idx_q + DIG_W'(1);
        end

        // Blink phase only advances on real frame wraps, never on enable.
        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!i_en) begin
            frame_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRM_W'(1);
            end
        end
    end

    always_comb begin
        lit = (state_q == S_ON) && on_phase && !(blink_ph_q && mask_sh_q[dig_idx_q]);
        enb_pin_d = {N_DIG{ENB_OFF_LVL}};
        for (int k = 0; k < N_DIG; k++) begin
            if (lit && dig_idx_q == DIG_W'(k)) begin
                enb_pin_d[k] = ~ENB_OFF_LVL;
            end
        end
        seg_pin_d = {SEG_W{SEG_OFF_LVL}};
        dp_pin_d  = SEG_OFF_LVL;
        if (lit) begin
            seg_pin_d = seg_sh_q[int'(dig_idx_q)*SEG_W +: SEG_W] ^ {SEG_W{SEG_OFF_LVL}};
            dp_pin_d  = dp_sh_q[dig_idx_q] ^ SEG_OFF_LVL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_idx_q   <= '0;
            frame_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            fs_q        <= 1'b0;
            seg_sh_q    <= '0;
            dp_sh_q     <= '0;
            mask_sh_q   <= '0;
            seg_pin_q   <= {SEG_W{SEG_OFF_LVL}};
            dp_pin_q    <= SEG_OFF_LVL;
            enb_pin_q   <= {N_DIG{ENB_OFF_LVL}};
            idx_pin_q   <= '0;
            fs_pin_q    <= 1'b0;
        end else begin
            dig_idx_q   <= dig_idx_d;
            frame_cnt_q <= frame_cnt_d;
            blink_ph_q  <= blink_ph_d;
            fs_q        <= frame_start;
            if (frame_start) begin
                seg_sh_q  <= i_digit_seg;
                dp_sh_q   <= i_dp;
                mask_sh_q <= i_blink_mask;
            end
            seg_pin_q   <= seg_pin_d;
            dp_pin_q    <= dp_pin_d;
            enb_pin_q   <= enb_pin_d;
            idx_pin_q   <= dig_idx_q;
            fs_pin_q    <= fs_q;
        end
    end

    assign o_seg         = seg_pin_q;
    assign o_seg_dp      = dp_pin_q;
    assign o_seg_enb     = enb_pin_q;
    assign o_dig_idx     = idx_pin_q;
    assign o_frame_start = fs_pin_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench: stimulus queues one expected record per frame, the monitor
// pops a record on each o_frame_start and checks every pin cycle against it.
module tb_fnd_scan_ctrl;
    import fnd_pkg::*;

    localparam int N_DIG = 3;
    localparam int SEG_W = 7;
    localparam int SCAN_DIV = 8;
    localparam int BLANK_CYC = 2;
    localparam logic [13:0] PINS_OFF = {3'b111, 7'h00, 1'b0, 2'd0, 1'b0};

    typedef struct packed {
        logic [20:0] seg;
        logic [2:0]  dp;
        logic [2:0]  lit;
        int          len;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_en = 1'b1;
    logic [N_DIG*SEG_W-1:0] i_digit_seg;
    logic [N_DIG-1:0] i_dp, i_blink_mask;
    logic [SEG_W-1:0] o_seg;
    logic o_seg_dp;
    logic [N_DIG-1:0] o_seg_enb;
    logic [1:0] o_dig_idx;
    logic o_frame_start;

    frame_t exp_q[$];
    frame_t cur;
    logic in_win = 1'b0;
    int win_j = 0;
    int n_total = 0;
    int n_pass = 0;

    fnd_scan_ctrl #(
        .N_DIG(N_DIG), .SEG_W(SEG_W), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
        .BLINK_FRAMES(2), .ENB_ACT_LOW(1), .SEG_ACT_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_digit_seg(i_digit_seg), .i_dp(i_dp),
        .i_blink_mask(i_blink_mask), .o_seg(o_seg), .o_seg_dp(o_seg_dp),
        .o_seg_enb(o_seg_enb), .o_dig_idx(o_dig_idx), .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int j, input logic [13:0] act,
                         input logic [13:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s j=%0d got %h expected %h", name, j, act, exp_v);
    endtask

    function automatic frame_t mk(input logic [20:0] s, input logic [2:0] dp,
                                  input logic [2:0] lit, input int len);
        frame_t f;
        f.seg = s; f.dp = dp; f.lit = lit; f.len = len;
        return f;
    endfunction

    // Pin image {enb, seg, dp, idx, frame_start} for cycle j of a frame.
    function automatic logic [13:0] exp_pins(input frame_t f, input int j);
        int d;
        int t;
        logic [2:0] enb;
        logic [6:0] seg;
        logic dp;
        d = j / SCAN_DIV;
        t = j % SCAN_DIV;
        enb = 3'b111;
        seg = 7'h00;
        dp = 1'b0;
        if (t >= BLANK_CYC && f.lit[d]) begin
            enb[d] = 1'b0;
            seg = f.seg[d*SEG_W +: SEG_W];
            dp = f.dp[d];
        end
        return {enb, seg, dp, 2'(d), (j == 0)};
    endfunction

    initial begin
        logic [13:0] act;
        @(posedge clk);
        forever begin
            @(negedge clk);
            act = {o_seg_enb, o_seg, o_seg_dp, o_dig_idx, o_frame_start};
            check("enb_onehot", win_j, {13'b0, ($countones(~o_seg_enb) <= 1)}, 14'd1);
            if (o_frame_start) begin
                check("frame_boundary", win_j, {13'b0, in_win}, 14'd0);
                check("frame_expected", win_j, {13'b0, (exp_q.size() != 0)}, 14'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    in_win = 1'b1;
                    win_j = 0;
                end
            end
            if (in_win) begin
                check("pins_frame", win_j, act, exp_pins(cur, win_j));
                win_j++;
                if (win_j == cur.len) in_win = 1'b0;
            end else begin
                check("pins_off", win_j, act, PINS_OFF);
            end
        end
    end

    initial begin
        logic [20:0] sa, sb, sc;
        sa = {GLYPH[1], GLYPH[2], GLYPH[0]};
        sb = {GLYPH[1], GLYPH[2], GLYPH[8]};
        sc = {GLYPH[9], GLYPH[2], GLYPH[8]};
        i_digit_seg = sa;
        i_dp = 3'b010;
        i_blink_mask = 3'b010;
        // Phase A: digit 0 edited mid-frame 1, blink hides digit 1 from frame 2, disable in frame 3.
        exp_q.push_back(mk(sa, 3'b010, 3'b111, 24));
        exp_q.push_back(mk(sa, 3'b010, 3'b111, 24));
        exp_q.push_back(mk(sb, 3'b010, 3'b101, 24));
        exp_q.push_back(mk(sb, 3'b010, 3'b101, 13));
        // Phase B: re-enable restarts blink, full blink period, reset in frame 5.
        exp_q.push_back(mk(sc, 3'b001, 3'b111, 24));
        exp_q.push_back(mk(sc, 3'b001, 3'b111, 24));
        exp_q.push_back(mk(sc, 3'b001, 3'b101, 24));
        exp_q.push_back(mk(sc, 3'b001, 3'b101, 24));
        exp_q.push_back(mk(sc, 3'b001, 3'b111, 24));
        exp_q.push_back(mk(sc, 3'b001, 3'b111, 12));
        // Phase C: fresh frame after reset, then disable.
        exp_q.push_back(mk(sc, 3'b001, 3'b111, 24));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (35) @(posedge clk);
        #1 i_digit_seg[6:0] = GLYPH[8];
        repeat (50) @(posedge clk);
        #1 i_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        i_digit_seg[20:14] = GLYPH[9];
        i_dp = 3'b001;
        i_en = 1'b1;
        repeat (133) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (24) @(posedge clk);
        #1 i_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("frames_left", 0, 14'(exp_q.size()), 14'd0);
        check("window_open", 0, {13'b0, in_win}, 14'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
